// File: rtl/spike_train_decoder.sv
`default_nettype none
// ============================================================================
// spike_train_decoder : hysteretic spike detector with ISI, burst and rate stats
// Revision: 1.0
// ============================================================================
module spike_train_decoder #(
  parameter int ISI_W = 16,
  parameter int WIN_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       sample_in,
  input  logic             sample_valid,
  input  logic [7:0]       thr_hi,
  input  logic [7:0]       thr_lo,
  input  logic [ISI_W-1:0] burst_gap,
  input  logic [WIN_W-1:0] win_len,
  output logic             spike_pulse,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid,
  input  logic             isi_ready,
  output logic             isi_overrun,
  output logic             burst_active,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid
);

  localparam logic [ISI_W-1:0] ISI_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ARMED   = 1'b0,
    REFRACT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             have_ref_q, have_ref_d;
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
  logic [ISI_W-1:0] isi_out_q, isi_out_d;
  logic             isi_valid_q, isi_valid_d;
  logic             isi_overrun_q, isi_overrun_d;
  logic             burst_active_q, burst_active_d;
  logic             spike_pulse_q, spike_pulse_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d;
  logic [CNT_W-1:0] rate_out_q, rate_out_d;
  logic             rate_valid_q, rate_valid_d;

  logic             w_spike;
  logic [ISI_W-1:0] w_isi_inc;
  logic [WIN_W:0]   w_win_next;
  logic [CNT_W-1:0] w_spk_next;

  always_comb begin
    state_d        = state_q;
    have_ref_d     = have_ref_q;
    isi_cnt_d      = isi_cnt_q;
    isi_out_d      = isi_out_q;
    isi_valid_d    = isi_valid_q;
    isi_overrun_d  = isi_overrun_q;
    burst_active_d = burst_active_q;
    spike_pulse_d  = 1'b0;
    win_cnt_d      = win_cnt_q;
    spk_cnt_d      = spk_cnt_q;
    rate_out_d     = rate_out_q;
    rate_valid_d   = 1'b0;
    w_spike        = 1'b0;
    w_isi_inc      = (isi_cnt_q != ISI_MAX) ? isi_cnt_q + 1'b1 : isi_cnt_q;
    w_win_next     = {1'b0, win_cnt_q} + 1'b1;
    w_spk_next     = spk_cnt_q;

    // The handshake is the only activity allowed on cycles without a sample
    if (isi_valid_q && isi_ready) begin
      isi_valid_d = 1'b0;
    end

    if (sample_valid) begin
      case (state_q)
        ARMED: begin
          if ($signed(sample_in) > $signed(thr_hi)) begin
            w_spike = 1'b1;
            state_d = REFRACT;
          end
        end
        REFRACT: begin
          if ($signed(sample_in) < $signed(thr_lo)) begin
            state_d = ARMED;
          end
        end
        default: state_d = ARMED;
      endcase

      spike_pulse_d = w_spike;

      if (w_spike) begin
        // The spike sample opens the next interval, so the counter restarts at 1
        isi_cnt_d  = ISI_W'(1);
        have_ref_d = 1'b1;
        if (have_ref_q) begin
          if (isi_valid_q && !isi_ready) begin
            isi_overrun_d = 1'b1;
          end else begin
            isi_out_d   = isi_cnt_q;
            isi_valid_d = 1'b1;
          end
          burst_active_d = (isi_cnt_q <= burst_gap);
        end
      end else begin
        isi_cnt_d = w_isi_inc;
        if (w_isi_inc > burst_gap) begin
          burst_active_d = 1'b0;
        end
      end

      if (win_len == '0) begin
        win_cnt_d = '0;
        spk_cnt_d = '0;
      end else begin
        if (w_spike && (spk_cnt_q != CNT_MAX)) begin
          w_spk_next = spk_cnt_q + 1'b1;
        end
        // >= rather than == so a shortened window closes on the next sample
        if (w_win_next >= {1'b0, win_len}) begin
          rate_out_d   = w_spk_next;
          rate_valid_d = 1'b1;
          win_cnt_d    = '0;
          spk_cnt_d    = '0;
        end else begin
          win_cnt_d = w_win_next[WIN_W-1:0];
          spk_cnt_d = w_spk_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ARMED;
      have_ref_q     <= 1'b0;
      isi_cnt_q      <= '0;
      isi_out_q      <= '0;
      isi_valid_q    <= 1'b0;
      isi_overrun_q  <= 1'b0;
      burst_active_q <= 1'b0;
      spike_pulse_q  <= 1'b0;
      win_cnt_q      <= '0;
      spk_cnt_q      <= '0;
      rate_out_q     <= '0;
      rate_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      have_ref_q     <= have_ref_d;
      isi_cnt_q      <= isi_cnt_d;
      isi_out_q      <= isi_out_d;
      isi_valid_q    <= isi_valid_d;
      isi_overrun_q  <= isi_overrun_d;
      burst_active_q <= burst_active_d;
      spike_pulse_q  <= spike_pulse_d;
      win_cnt_q      <= win_cnt_d;
      spk_cnt_q      <= spk_cnt_d;
      rate_out_q     <= rate_out_d;
      rate_valid_q   <= rate_valid_d;
    end
  end

  assign spike_pulse  = spike_pulse_q;
  assign isi_out      = isi_out_q;
  assign isi_valid    = isi_valid_q;
  assign isi_overrun  = isi_overrun_q;
  assign burst_active = burst_active_q;
  assign rate_out     = rate_out_q;
  assign rate_valid   = rate_valid_q;

endmodule
`default_nettype wire
